// File: rtl/nfa_pkg.sv
// Shared types and constants for the line-anchored character-class matcher.
package nfa_pkg;

    typedef enum logic [1:0] {
        LINE_START = 2'd0,
        IN_RUN     = 2'd1,
        DEAD       = 2'd2
    } state_t;

    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

endpackage

// File: rtl/nfa_class_match.sv
// Combinational character classifier: optional ASCII case fold, then a test
// against NUM_RANGES inclusive ranges; terminator detection uses the raw char.
module nfa_class_match
    import nfa_pkg::*;
#(
    parameter int                            CHAR_W     = 8,
    parameter int                            NUM_RANGES = 1,
    parameter logic [NUM_RANGES*CHAR_W-1:0]  RANGE_LO   = 8'h30,
    parameter logic [NUM_RANGES*CHAR_W-1:0]  RANGE_HI   = 8'h39,
    parameter int                            NOCASE     = 0,
    parameter logic [CHAR_W-1:0]             EOL_CHAR   = EOL_DEFAULT
) (
    input  logic [CHAR_W-1:0] i_char,
    output logic              o_in_class,
    output logic              o_is_eol
);

    localparam logic [CHAR_W-1:0] UPPER_A = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0] UPPER_Z = CHAR_W'(8'h5A);
    localparam logic [CHAR_W-1:0] CASE_OFS = CHAR_W'(8'h20);

    logic [CHAR_W-1:0] w_folded;

    always_comb begin
        w_folded = i_char;
        if (NOCASE != 0 && i_char >= UPPER_A && i_char <= UPPER_Z) begin
            w_folded = i_char + CASE_OFS;
        end
    end

    always_comb begin
        o_in_class = 1'b0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            if (w_folded >= RANGE_LO[i*CHAR_W +: CHAR_W] &&
                w_folded <= RANGE_HI[i*CHAR_W +: CHAR_W]) begin
                o_in_class = 1'b1;
            end
        end
    end

    assign o_is_eol = (i_char == EOL_CHAR);

endmodule

// File: rtl/nfa_line_class_engine.sv
// Matches /^[class]{MIN_REP,MAX_REP}$/m over the en-qualified character stream.
// Optional saturating match counter built only when NFA_MATCH_COUNT_EN is defined.
module nfa_line_class_engine
    import nfa_pkg::*;
#(
    parameter int                            CHAR_W     = 8,
    parameter int                            NUM_RANGES = 1,
    parameter logic [NUM_RANGES*CHAR_W-1:0]  RANGE_LO   = 8'h30,
    parameter logic [NUM_RANGES*CHAR_W-1:0]  RANGE_HI   = 8'h39,
    parameter int                            NOCASE     = 0,
    parameter int                            MIN_REP    = 2,
    parameter int                            MAX_REP    = 4,
    parameter logic [CHAR_W-1:0]             EOL_CHAR   = EOL_DEFAULT,
    parameter int                            CNT_W      = 16
) (
    input  logic              clk,
    input  logic              sod,
    input  logic              en,
    input  logic [CHAR_W-1:0] char,
    output logic              out,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count
);

    // One code above MAX_REP marks "too long" so long runs can never wrap back into range.
    localparam int                RUN_W   = $clog2(MAX_REP + 2);
    localparam logic [RUN_W-1:0]  MIN_R   = RUN_W'(MIN_REP);
    localparam logic [RUN_W-1:0]  MAX_R   = RUN_W'(MAX_REP);
    localparam logic [RUN_W-1:0]  RUN_SAT = RUN_W'(MAX_REP + 1);
    localparam logic [RUN_W-1:0]  RUN_ONE = RUN_W'(1);

    state_t            r_state;
    logic [RUN_W-1:0]  r_run;
    logic              r_out;
    logic              r_pulse;
    logic              w_in_class;
    logic              w_is_eol;
    logic              w_match;

    nfa_class_match #(
        .CHAR_W     (CHAR_W),
        .NUM_RANGES (NUM_RANGES),
        .RANGE_LO   (RANGE_LO),
        .RANGE_HI   (RANGE_HI),
        .NOCASE     (NOCASE),
        .EOL_CHAR   (EOL_CHAR)
    ) u_class (
        .i_char     (char),
        .o_in_class (w_in_class),
        .o_is_eol   (w_is_eol)
    );

    assign w_match = (r_state == IN_RUN && r_run >= MIN_R && r_run <= MAX_R) ||
                     (r_state == LINE_START && MIN_REP == 0);

    // The terminator is tested first so it wins even when it lies inside a range.
    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            r_state <= LINE_START;
            r_run   <= '0;
            r_out   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (en) begin
                if (w_is_eol) begin
                    r_state <= LINE_START;
                    r_run   <= '0;
                    if (w_match) begin
                        r_pulse <= 1'b1;
                        r_out   <= 1'b1;
                    end
                end else begin
                    case (r_state)
                        LINE_START: begin
                            if (w_in_class) begin
                                r_state <= IN_RUN;
                                r_run   <= RUN_ONE;
                            end else begin
                                r_state <= DEAD;
                                r_run   <= '0;
                            end
                        end
                        IN_RUN: begin
                            if (w_in_class) begin
                                if (r_run != RUN_SAT) begin
                                    r_run <= r_run + RUN_ONE;
                                end
                            end else begin
                                r_state <= DEAD;
                                r_run   <= '0;
                            end
                        end
                        DEAD: begin
                            r_state <= DEAD;
                        end
                        default: begin
                            r_state <= LINE_START;
                            r_run   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign out         = r_out;
    assign match_pulse = r_pulse;

`ifdef NFA_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_count;
    logic             w_match_accept;

    assign w_match_accept = en && w_is_eol && w_match;

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            r_count <= '0;
        end else if (w_match_accept && r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: doc/nfa_line_class_engine.md
NFA_LINE_CLASS_ENGINE -- requirements
Module: nfa_line_class_engine

Interface
REQ-001 SHALL have parameter CHAR_W, default 8: width of the character bus.
REQ-002 SHALL have parameter NUM_RANGES, default 1, legal 1..4: number of inclusive ranges in the character class.
REQ-003 SHALL have parameter RANGE_LO, default {8'h30}: packed NUM_RANGES*CHAR_W lower bounds, range 0 in LSBs.
REQ-004 SHALL have parameter RANGE_HI, default {8'h39}: packed NUM_RANGES*CHAR_W upper bounds, range 0 in LSBs.
REQ-005 SHALL have parameter NOCASE, default 0: when 1, fold 8'h41..8'h5A to lowercase before class compare.
REQ-006 SHALL have parameter MIN_REP, default 2, and MAX_REP, default 4, with 0 <= MIN_REP <= MAX_REP <= 255.
REQ-007 SHALL have parameter EOL_CHAR, default 8'h0A: line terminator.
REQ-008 SHALL have parameter CNT_W, default 16: match counter width.
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 sod  input  1  start-of-data reset, asynchronous, active-high.
REQ-011 en  input  1  character-valid qualifier; char consumed only on a clk edge with en=1.
REQ-012 char  input  CHAR_W  current character.
REQ-013 out  output  1  sticky "any match since sod".
REQ-014 match_pulse  output  1  one-cycle pulse per completed line match.
REQ-015 match_count  output  CNT_W  number of line matches since sod, saturating.

Function
REQ-016 SHALL implement the line-anchored multiline pattern /^[class]{MIN_REP,MAX_REP}$/m over the accepted character stream.
REQ-017 SHALL run FSM states LINE_START, IN_RUN, DEAD; reset state LINE_START.
REQ-018 LINE_START, accepted in-class char -> IN_RUN, run=1; non-class non-EOL -> DEAD; EOL -> LINE_START.
REQ-019 IN_RUN, in-class char -> run+1, saturating at MAX_REP+1; non-class non-EOL -> DEAD; EOL -> LINE_START, run=0.
REQ-020 DEAD ignores all chars except EOL, which -> LINE_START with no match.
REQ-021 A match SHALL be decided on accepted EOL when state is IN_RUN with MIN_REP <= run <= MAX_REP, or state is LINE_START and MIN_REP == 0.
REQ-022 EOL_CHAR SHALL take precedence over class membership when it also lies inside a range.
REQ-023 match_pulse SHALL be registered, high exactly in the cycle after the clk edge that accepted the matching EOL.
REQ-024 out SHALL be set in the same cycle as match_pulse and hold until sod.
REQ-025 match_count SHALL increment with each match_pulse and hold at all-ones, no wrap.
REQ-026 With en=0, state, run, out and match_count SHALL hold and match_pulse SHALL be 0 next cycle.
REQ-027 run SHALL be ceil(log2(MAX_REP+2)) bits wide; no comparison SHALL overflow it.

Reset
REQ-028 sod=1 SHALL immediately force state=LINE_START, run=0, out=0, match_pulse=0, match_count=0, regardless of clk or en.
REQ-029 sod asserted mid-line SHALL discard the partial line; the first accepted char after release starts a new line.

Configuration
REQ-030 With macro NFA_MATCH_COUNT_EN defined, match_count SHALL behave per REQ-025.
REQ-031 Without NFA_MATCH_COUNT_EN, the counter SHALL not be built and match_count SHALL be constant 0; out and match_pulse are unchanged.

Structure
REQ-032 Package nfa_pkg SHALL hold the FSM state enum (LINE_START, IN_RUN, DEAD) and the default EOL constant 8'h0A.
REQ-033 Sub-module nfa_class_match SHALL hold the combinational case-fold and range compare, producing in_class and is_eol.

Verification
REQ-034 Defaults, en=1, stream "12\n" -> match_pulse=1 one cycle after '\n', out=1, match_count=1.
REQ-035 Defaults, "12345\n" then "9\n" -> no match_pulse, out=0, match_count=0.
REQ-036 Defaults, "1a23\n" -> DEAD after 'a', no match; next line "4567\n" -> match, match_count=1.
REQ-037 Defaults, "3", then one cycle en=0 with char='\n', then "4\n" -> single match after final '\n'.
REQ-038 Defaults, "12", sod pulse, then "\n" -> no match; then "55\n" -> match, match_count=1.
REQ-039 CNT_W=2, five matching lines "00\n" -> match_count 1,2,3,3,3; match_pulse on all five.
